// File: rtl/matmul_result_drain_if.sv
// Result stream bus between the drain block and its sink.
//   master: drives out_data/out_valid/out_row/out_col/out_row_last/out_last, samples out_ready
//   slave : the sink side, drives out_ready
interface matmul_result_drain_if #(
  parameter int unsigned ACC_WIDTH = 16
);
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [2:0]           out_row;
  logic [2:0]           out_col;
  logic                 out_row_last;
  logic                 out_last;

  modport master (
    output out_data, out_valid, out_row, out_col, out_row_last, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_row, out_col, out_row_last, out_last,
    output out_ready
  );
endinterface

// File: rtl/matmul_result_drain.sv
// Snapshots an 8x8 matrix-multiply result on the rising edge of done_in and
// streams it out row-major, one element per valid/ready transfer.
//   clk, reset      : clock, asynchronous active-high reset
//   done_in         : completion level from the multiplier (rising edge = capture)
//   C_matrix        : flattened result, element k at [k*ACC_WIDTH +: ACC_WIDTH]
//   busy            : high while streaming
//   overrun         : sticky, set by a capture that arrives mid-stream
//   clear_err       : clears overrun (a simultaneous set wins)
//   drain           : result stream (data, valid/ready, row/col, row_last, last)
module matmul_result_drain #(
  parameter int unsigned ACC_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      done_in,
  input  logic [ACC_WIDTH*64-1:0]   C_matrix,
  output logic                      busy,
  output logic                      overrun,
  input  logic                      clear_err,
  matmul_result_drain_if.master     drain
);

  localparam int unsigned NUM_ELEM = 64;
  localparam int unsigned IDX_W    = 6;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;
  logic [ACC_WIDTH-1:0] data_q, data_d;
  logic                 row_last_q, row_last_d;
  logic                 last_q, last_d;
  logic [ACC_WIDTH-1:0] snap_q [NUM_ELEM];
  logic [ACC_WIDTH-1:0] snap_d [NUM_ELEM];

  logic capture_c;
  logic xfer_c;
  logic load_c;
  logic ovr_set_c;

  assign capture_c = done_in & ~done_q;
  assign xfer_c    = (state_q == STREAM) & drain.out_ready;

  // Next-state, index, snapshot load and registered output values.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = done_in;
    snap_d    = snap_q;
    load_c    = 1'b0;
    ovr_set_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (capture_c) begin
          load_c  = 1'b1;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer_c && (idx_q == LAST_IDX)) begin
          idx_d = '0;
          // A capture landing on the final transfer chains straight into a new stream.
          if (capture_c) begin
            load_c = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer_c) begin
            idx_d = idx_q + IDX_W'(1);
          end
          if (capture_c) begin
            ovr_set_c = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_c) begin
      for (int unsigned k = 0; k < NUM_ELEM; k++) begin
        snap_d[k] = C_matrix[k*ACC_WIDTH +: ACC_WIDTH];
      end
    end

    // On a load idx_d is 0, so the first element comes straight from the input.
    if (state_d == STREAM) begin
      data_d = load_c ? C_matrix[ACC_WIDTH-1:0] : snap_q[idx_d];
    end else begin
      data_d = '0;
    end
    row_last_d = (state_d == STREAM) && (idx_d[2:0] == 3'd7);
    last_d     = (state_d == STREAM) && (idx_d == LAST_IDX);

    if (ovr_set_c) begin
      overrun_d = 1'b1;
    end else if (clear_err) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      data_q     <= '0;
      row_last_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      data_q     <= data_d;
      row_last_q <= row_last_d;
      last_q     <= last_d;
    end
  end

  // Snapshot storage; contents are irrelevant until the next capture, so no reset.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  assign drain.out_valid    = (state_q == STREAM);
  assign drain.out_data     = data_q;
  assign drain.out_row      = idx_q[5:3];
  assign drain.out_col      = idx_q[2:0];
  assign drain.out_row_last = row_last_q;
  assign drain.out_last     = last_q;
  assign busy               = (state_q == STREAM);
  assign overrun            = overrun_q;

endmodule

// File: doc/matmul_result_drain.md
MATMUL_RESULT_DRAIN -- requirements
Module: matmul_result_drain

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 16, the width of one result element.
REQ-002 SHALL have port clk, input, 1 bit, the clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-004 SHALL have port done_in, input, 1 bit, the matrix-multiply completion level; it stays high once asserted.
REQ-005 SHALL have port C_matrix, input, ACC_WIDTH*64 bits, the flattened row-major signed result; element k occupies bits [k*ACC_WIDTH +: ACC_WIDTH].
REQ-006 SHALL have port out_data, output, ACC_WIDTH bits, the streamed result element.
REQ-007 SHALL have port out_valid, output, 1 bit, meaning out_data is valid.
REQ-008 SHALL have port out_ready, input, 1 bit, meaning the sink accepts out_data.
REQ-009 SHALL have ports out_row and out_col, output, 3 bits each, the row and column of out_data.
REQ-010 SHALL have port out_row_last, output, 1 bit, high when out_col==7.
REQ-011 SHALL have port out_last, output, 1 bit, high when the element is (7,7).
REQ-012 SHALL have port busy, output, 1 bit, high while streaming.
REQ-013 SHALL have port overrun, output, 1 bit, a sticky error flag.
REQ-014 SHALL have port clear_err, input, 1 bit, which clears overrun.

Function
REQ-015 SHALL register done_in into done_q; a capture event is done_in & ~done_q.
REQ-016 SHALL implement two states: IDLE and STREAM.
REQ-017 In IDLE, a capture event SHALL copy all 64 C_matrix elements into an internal snapshot buffer, set idx=0, and enter STREAM.
REQ-018 out_valid SHALL go high the cycle after the capture edge (1-cycle latency) and remain high throughout STREAM.
REQ-019 In STREAM, out_data SHALL equal snapshot[idx], with out_row=idx[5:3] and out_col=idx[2:0].
REQ-020 A transfer SHALL occur when out_valid & out_ready are both high; idx then increments by 1.
REQ-021 While out_ready is low, out_data, out_row, out_col, out_row_last and out_last SHALL hold stable.
REQ-022 On the transfer with idx==63, the block SHALL return to IDLE with out_valid low next cycle and idx=0, unless REQ-023 applies.
REQ-023 A capture event coinciding with the idx==63 transfer SHALL recapture C_matrix and remain in STREAM with idx=0, with no out_valid gap.
REQ-024 A capture event in STREAM at any other time SHALL leave the snapshot and idx unchanged and SHALL set overrun.
REQ-025 clear_err SHALL clear overrun next cycle; if a set and a clear coincide, the set SHALL win.
REQ-026 busy SHALL equal (state==STREAM).
REQ-027 All outputs SHALL be registered or decoded directly from registers; there SHALL be no combinational path from out_ready to out_valid.
REQ-028 Element values SHALL pass through bit-exact, with no sign change, truncation or saturation.
REQ-029 The snapshot buffer SHALL be isolated from C_matrix changes after capture.

Reset
REQ-030 While reset is high, the block SHALL force state=IDLE, idx=0, done_q=0, out_valid=0, out_data=0, out_row=0, out_col=0, out_row_last=0, out_last=0, busy=0 and overrun=0.
REQ-031 If done_in is high at reset release, the first clock SHALL be treated as a capture event.
REQ-032 Reset asserted mid-stream SHALL abort the stream immediately; the snapshot contents are don't-care.

Verification
REQ-033 C_matrix[k]=k, done_in rises, out_ready=1 -> out_valid rises 1 cycle later; 64 consecutive beats carry data 0..63; out_row_last on beats 7,15,...,63; out_last only on beat 63; busy drops after 65 cycles.
REQ-034 Same stimulus with out_ready toggled 1,0,0,1 repeatedly -> data sequence identical; outputs stable during stalls; no beat lost or duplicated.
REQ-035 C_matrix[k]=-k (16'hFFFF etc.), then C_matrix changed to all 0x1234 after capture -> streamed values remain -k, confirming snapshot isolation and sign preservation.
REQ-036 done_in pulsed low then high at beat 20 -> overrun=1, stream continues unchanged; clear_err at beat 40 -> overrun=0 next cycle; clear_err coincident with a new edge -> overrun stays 1.
REQ-037 Capture edge on the beat-63 handshake cycle with new C_matrix[k]=100+k -> next beat is data 100 at (0,0), out_valid never low.
REQ-038 reset asserted at beat 30 -> all outputs 0 asynchronously; done_in held high through reset release -> new stream starts at (0,0) one cycle after release.
